// File: rtl/clock_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clock_run_ctrl
// Brief    : Debounced run/step/fast key control and divided processor clock
//            with break handling, all in the 50 MHz domain.
// Revision : 1.0 - initial release
// ============================================================================
module clock_run_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SLOW_SHIFT      = 18
) (
    input  logic       iCLK_50,
    input  logic       iRST_n,
    input  logic       iKEY_RUN,
    input  logic       iKEY_STEP,
    input  logic       iKEY_FAST,
    input  logic       iBreak,
    input  logic [7:0] iFDIV,
    input  logic [7:0] iSTEP_N,
    output logic       oCPU_CLK,
    output logic       oCPU_CE,
    output logic [1:0] oSTATE,
    output logic       oFAST,
    output logic [7:0] oSTEPS_LEFT
);

    localparam int                c_DIV_W   = 26;
    localparam int                c_DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_HALT  = 2'b00,
        ST_RUN   = 2'b01,
        ST_STEP  = 2'b10,
        ST_BREAK = 2'b11
    } state_t;

    logic [2:0] w_key_raw;
    logic [2:0] w_press;

    assign w_key_raw = {iKEY_FAST, iKEY_STEP, iKEY_RUN};

    // Bit 0 = RUN, bit 1 = STEP, bit 2 = FAST; keys idle high.
    generate
        for (genvar k = 0; k < 3; k++) begin : g_key
            logic              meta_q;
            logic              sync_q;
            logic              level_q;
            logic              press_q;
            logic [c_DB_W-1:0] cnt_q;

            always_ff @(posedge iCLK_50 or negedge iRST_n) begin
                if (!iRST_n) begin
                    meta_q  <= 1'b1;
                    sync_q  <= 1'b1;
                    level_q <= 1'b1;
                    press_q <= 1'b0;
                    cnt_q   <= '0;
                end else begin
                    meta_q  <= w_key_raw[k];
                    sync_q  <= meta_q;
                    press_q <= 1'b0;
                    if (sync_q != level_q) begin
                        if (cnt_q == c_DB_LAST) begin
                            level_q <= sync_q;
                            press_q <= ~sync_q;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + c_DB_W'(1);
                        end
                    end else begin
                        cnt_q <= '0;
                    end
                end
            end

            assign w_press[k] = press_q;
        end
    endgenerate

    logic brk_meta_q;
    logic brk_sync_q;

    always_ff @(posedge iCLK_50 or negedge iRST_n) begin
        if (!iRST_n) begin
            brk_meta_q <= 1'b0;
            brk_sync_q <= 1'b0;
        end else begin
            brk_meta_q <= iBreak;
            brk_sync_q <= brk_meta_q;
        end
    end

    state_t             state_q;
    logic               cpu_clk_q;
    logic               cpu_ce_q;
    logic               fast_q;
    logic [7:0]         steps_q;
    logic [c_DIV_W-1:0] div_q;
    logic [c_DIV_W-1:0] div_cnt_q;

    logic [7:0]         w_fdiv;
    logic [7:0]         w_step_n;
    logic [c_DIV_W-1:0] w_div;
    logic               w_tick_en;
    logic               w_tick;
    logic               w_rise;

    assign w_fdiv    = (iFDIV == 8'd0) ? 8'd1 : iFDIV;
    assign w_step_n  = (iSTEP_N == 8'd0) ? 8'd1 : iSTEP_N;
    assign w_div     = fast_q ? c_DIV_W'(w_fdiv) : (c_DIV_W'(w_fdiv) << SLOW_SHIFT);
    // A high processor clock keeps ticking so it always parks low.
    assign w_tick_en = (state_q == ST_RUN) || (state_q == ST_STEP) || cpu_clk_q;
    assign w_tick    = w_tick_en && (div_cnt_q == (div_q - c_DIV_W'(1)));
    assign w_rise    = w_tick & ~cpu_clk_q;

    always_ff @(posedge iCLK_50 or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q   <= ST_HALT;
            cpu_clk_q <= 1'b0;
            cpu_ce_q  <= 1'b0;
            fast_q    <= 1'b0;
            steps_q   <= '0;
            div_q     <= c_DIV_W'(1);
            div_cnt_q <= '0;
        end else begin
            cpu_clk_q <= cpu_clk_q ^ w_tick;
            cpu_ce_q  <= w_rise;
            if (w_press[2]) begin
                fast_q <= ~fast_q;
            end

            if (w_tick) begin
                div_cnt_q <= '0;
                div_q     <= w_div;
            end else if (w_tick_en) begin
                div_cnt_q <= div_cnt_q + c_DIV_W'(1);
            end else begin
                div_cnt_q <= '0;
            end

            if (brk_sync_q) begin
                state_q <= ST_BREAK;
                steps_q <= '0;
            end else begin
                case (state_q)
                    ST_HALT, ST_BREAK: begin
                        if (w_press[0]) begin
                            state_q   <= ST_RUN;
                            div_cnt_q <= '0;
                            div_q     <= w_div;
                        end else if (w_press[1]) begin
                            state_q   <= ST_STEP;
                            steps_q   <= w_step_n;
                            div_cnt_q <= '0;
                            div_q     <= w_div;
                        end
                    end
                    ST_RUN: begin
                        if (w_press[0]) begin
                            state_q <= ST_HALT;
                        end
                    end
                    ST_STEP: begin
                        if (w_press[0] || (w_rise && steps_q == 8'd1)) begin
                            state_q <= ST_HALT;
                            steps_q <= '0;
                        end else if (w_rise) begin
                            steps_q <= steps_q - 8'd1;
                        end
                    end
                endcase
            end
        end
    end

    assign oCPU_CLK    = cpu_clk_q;
    assign oCPU_CE     = cpu_ce_q;
    assign oSTATE      = state_q;
    assign oFAST       = fast_q;
    assign oSTEPS_LEFT = steps_q;

endmodule
`default_nettype wire

// File: tb/tb_clock_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_run_ctrl
// Brief    : Directed and randomized bench for clock_run_ctrl against a
//            timestamp-based behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clock_run_ctrl;

    localparam int N  = 4;
    localparam int SH = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] keys;
    logic       brk;
    logic [7:0] fdiv;
    logic [7:0] stepn;
    logic       oCPU_CLK;
    logic       oCPU_CE;
    logic [1:0] oSTATE;
    logic       oFAST;
    logic [7:0] oSTEPS_LEFT;

    always #5 clk = ~clk;

    clock_run_ctrl #(
        .DEBOUNCE_CYCLES(N),
        .SLOW_SHIFT     (SH)
    ) dut (
        .iCLK_50    (clk),
        .iRST_n     (rst_n),
        .iKEY_RUN   (keys[0]),
        .iKEY_STEP  (keys[1]),
        .iKEY_FAST  (keys[2]),
        .iBreak     (brk),
        .iFDIV      (fdiv),
        .iSTEP_N    (stepn),
        .oCPU_CLK   (oCPU_CLK),
        .oCPU_CE    (oCPU_CE),
        .oSTATE     (oSTATE),
        .oFAST      (oFAST),
        .oSTEPS_LEFT(oSTEPS_LEFT)
    );

    int n_pass  = 0;
    int n_total = 0;
    int ce_seen = 0;

    // Model: debounce by "time since last agreement", divider by absolute tick time.
    int       mt;
    int       m_last [3];
    bit [2:0] m_p1, m_p2, m_lvl, m_pend;
    bit       m_b1, m_b2;
    int       m_state, m_steps, m_next;
    bit       m_fast, m_clk, m_ce;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic m_reset();
        mt      = 0;
        for (int k = 0; k < 3; k++) m_last[k] = 0;
        m_p1    = 3'b111;
        m_p2    = 3'b111;
        m_lvl   = 3'b111;
        m_pend  = 3'b000;
        m_b1    = 1'b0;
        m_b2    = 1'b0;
        m_state = 0;
        m_steps = 0;
        m_next  = -1;
        m_fast  = 1'b0;
        m_clk   = 1'b0;
        m_ce    = 1'b0;
    endtask

    task automatic m_edge();
        bit [2:0] pend_now = m_pend;
        bit       brk_now  = m_b2;
        int       f, d;
        bit       en, tick, rise;
        mt++;
        for (int k = 0; k < 3; k++) begin
            m_pend[k] = 1'b0;
            if (m_p2[k] == m_lvl[k]) m_last[k] = mt;
            else if (mt - m_last[k] >= N) begin
                m_lvl[k]  = m_p2[k];
                m_last[k] = mt;
                m_pend[k] = ~m_p2[k];
            end
        end
        m_p2 = m_p1;
        m_p1 = keys;
        m_b2 = m_b1;
        m_b1 = brk;
        f    = (fdiv == 8'd0) ? 1 : int'(fdiv);
        d    = m_fast ? f : f * (1 << SH);
        en   = (m_state == 1) || (m_state == 2) || m_clk;
        tick = en && (mt == m_next);
        rise = tick && !m_clk;
        if (tick) begin
            m_clk  = !m_clk;
            m_next = mt + d;
        end
        m_ce = rise;
        if (brk_now) begin
            m_state = 3;
            m_steps = 0;
        end else if (m_state == 0 || m_state == 3) begin
            if (pend_now[0]) begin
                m_state = 1;
                m_next  = mt + d;
            end else if (pend_now[1]) begin
                m_state = 2;
                m_steps = (stepn == 8'd0) ? 1 : int'(stepn);
                m_next  = mt + d;
            end
        end else if (m_state == 1) begin
            if (pend_now[0]) m_state = 0;
        end else begin
            if (pend_now[0] || (rise && m_steps == 1)) begin
                m_state = 0;
                m_steps = 0;
            end else if (rise) m_steps = m_steps - 1;
        end
        if (pend_now[2]) m_fast = !m_fast;
    endtask

    task automatic cyc();
        m_edge();
        @(posedge clk);
        #1;
        if (oCPU_CE === 1'b1) ce_seen++;
        chk("cpu_clk", oCPU_CLK, m_clk);
        chk("cpu_ce", oCPU_CE, m_ce);
        chk("state", oSTATE, m_state);
        chk("fast", oFAST, m_fast);
        chk("steps_left", oSTEPS_LEFT, m_steps);
    endtask

    task automatic press(input int k, input int lo, input int hi);
        keys[k] = 1'b0;
        repeat (lo) cyc();
        keys[k] = 1'b1;
        repeat (hi) cyc();
    endtask

    task automatic ce_gap(output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (oCPU_CE !== 1'b1 && n < 200);
    endtask

    task automatic wait_state(input int s);
        int g = 0;
        while (oSTATE !== 2'(s) && g < 40) begin
            cyc();
            g++;
        end
        chk("wait_state", oSTATE, s);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_clk"}, oCPU_CLK, 0);
        chk({tag, "_ce"}, oCPU_CE, 0);
        chk({tag, "_state"}, oSTATE, 0);
        chk({tag, "_fast"}, oFAST, 0);
        chk({tag, "_steps"}, oSTEPS_LEFT, 0);
    endtask

    initial begin
        int n;
        int g;
        rst_n = 1'b1;
        keys  = 3'b111;
        brk   = 1'b0;
        fdiv  = 8'd3;
        stepn = 8'd5;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        m_reset();

        // Fast mode, divisor 3: first CE after 3 cycles, period 6.
        press(2, 6, 10);
        chk("fast_on", oFAST, 1);
        press(0, 6, 0);
        wait_state(1);
        ce_gap(n);
        chk("first_ce_latency", n, 3);
        ce_gap(n);
        chk("ce_period_div3", n, 6);
        repeat (20) cyc();
        press(0, 6, 12);
        chk("halt_after_run", oSTATE, 0);

        // Step of 5 cycles with divisor 1.
        fdiv = 8'd1;
        stepn = 8'd5;
        repeat (4) cyc();
        ce_seen = 0;
        press(1, 6, 30);
        chk("step_ce_count", ce_seen, 5);
        chk("step_done_state", oSTATE, 0);
        chk("step_done_clk", oCPU_CLK, 0);

        // Break while the processor clock is high.
        fdiv = 8'd3;
        press(0, 6, 0);
        g = 0;
        while (!(oSTATE === 2'b01 && oCPU_CLK === 1'b1) && g < 40) begin
            cyc();
            g++;
        end
        chk("run_clk_high", oCPU_CLK, 1);
        ce_seen = 0;
        brk = 1'b1;
        repeat (3) cyc();
        brk = 1'b0;
        repeat (20) cyc();
        chk("break_state", oSTATE, 3);
        chk("break_no_ce", ce_seen, 0);
        chk("break_clk_low", oCPU_CLK, 0);
        press(0, 6, 10);
        chk("resume_run", oSTATE, 1);

        // Glitch rejection versus a real press.
        press(0, 3, 10);
        chk("glitch_ignored", oSTATE, 1);
        press(0, 6, 10);
        chk("press_halts", oSTATE, 0);

        // Slow mode divisor 2 -> 8; then fast with divisor 0 -> 1.
        press(2, 6, 10);
        chk("slow_sel", oFAST, 0);
        fdiv = 8'd2;
        press(0, 6, 0);
        wait_state(1);
        ce_gap(n);
        chk("first_ce_slow", n, 8);
        ce_gap(n);
        chk("period_slow", n, 16);
        fdiv = 8'd0;
        press(2, 6, 10);
        repeat (20) cyc();
        ce_gap(n);
        ce_gap(n);
        chk("period_div0", n, 2);
        press(0, 6, 10);

        // Asynchronous reset in the middle of a step.
        fdiv = 8'd2;
        stepn = 8'd8;
        press(1, 6, 0);
        g = 0;
        while (oSTEPS_LEFT !== 8'd3 && g < 200) begin
            cyc();
            g++;
        end
        chk("steps_reach3", oSTEPS_LEFT, 3);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midstep_reset");
        m_reset();
        #1 rst_n = 1'b1;
        ce_seen = 0;
        repeat (20) cyc();
        chk("no_ce_after_reset", ce_seen, 0);

        // Randomized traffic.
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 7))
                0: press(0, $urandom_range(1, 7), $urandom_range(5, 20));
                1: press(1, $urandom_range(1, 7), $urandom_range(5, 20));
                2: press(2, $urandom_range(1, 7), $urandom_range(5, 20));
                3: begin
                    brk = 1'b1;
                    repeat ($urandom_range(1, 4)) cyc();
                    brk = 1'b0;
                    repeat (3) cyc();
                end
                4: fdiv = 8'($urandom_range(0, 4));
                5: stepn = 8'($urandom_range(0, 6));
                6: repeat ($urandom_range(1, 30)) cyc();
                default: begin
                    keys[1:0] = 2'b00;
                    repeat (6) cyc();
                    keys[1:0] = 2'b11;
                    repeat (10) cyc();
                end
            endcase
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clock_run_ctrl.md
CLOCK_RUN_CTRL -- requirements
Module: clock_run_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, is the number of stable iCLK_50 cycles a key must hold before it is accepted (10 ms).
REQ-002 Parameter SLOW_SHIFT, default 18, is the left-shift applied to the divisor in slow mode.
REQ-003 Port iCLK_50, input, 1 bit, is the single 50 MHz clock; all flops are clocked on its rising edge.
REQ-004 Port iRST_n, input, 1 bit, is the asynchronous active-low reset.
REQ-005 Ports iKEY_RUN, iKEY_STEP and iKEY_FAST, inputs, 1 bit each, are raw active-low push-buttons asynchronous to iCLK_50.
REQ-006 Port iBreak, input, 1 bit, is the asynchronous active-high break request from the processor.
REQ-007 Port iFDIV, input, 8 bits, is the half-period divisor for the processor clock.
REQ-008 Port iSTEP_N, input, 8 bits, is the number of processor cycles per step command.
REQ-009 Port oCPU_CLK, output, 1 bit, is the generated processor clock.
REQ-010 Port oCPU_CE, output, 1 bit, is a one-iCLK_50-cycle pulse coincident with each rising transition of oCPU_CLK.
REQ-011 Port oSTATE, output, 2 bits, encodes the current state: HALT=00, RUN=01, STEP=10, BREAK=11.
REQ-012 Port oFAST, output, 1 bit, is 1 when fast mode is selected and 0 when slow mode is selected.
REQ-013 Port oSTEPS_LEFT, output, 8 bits, is the remaining processor cycles of the current step command.

Function
REQ-014 Each key and iBreak SHALL pass through a 2-flop synchronizer before any use.
REQ-015 Each synchronized key SHALL feed a debounce counter; the debounced level changes only after the input differs from it for DEBOUNCE_CYCLES consecutive cycles.
REQ-016 A 1→0 transition of a debounced key SHALL produce exactly one press pulse lasting one cycle.
REQ-017 A press of iKEY_FAST SHALL toggle oFAST in any state.
REQ-018 Effective divisor D SHALL be max(iFDIV,1) in fast mode and max(iFDIV,1)<<SLOW_SHIFT (26-bit counter, no overflow) in slow mode; iFDIV and oFAST are sampled only at tick boundaries.
REQ-019 While ticking is enabled, a tick SHALL occur every D cycles; each tick toggles oCPU_CLK, and a tick that drives oCPU_CLK 0→1 asserts oCPU_CE in the same cycle.
REQ-020 Ticking SHALL be enabled in RUN, in STEP, and while finishing a cycle in HALT or BREAK until oCPU_CLK is 0; oCPU_CLK SHALL never stop high.
REQ-021 The divider counter SHALL clear on entry to RUN or STEP from HALT or BREAK, so the first rising edge occurs exactly D cycles after entry.
REQ-022 In HALT, a RUN press SHALL go to RUN, and a STEP press SHALL load oSTEPS_LEFT with max(iSTEP_N,1) and go to STEP.
REQ-023 In RUN, a RUN press SHALL go to HALT; STEP presses are ignored.
REQ-024 In STEP, oSTEPS_LEFT SHALL decrement on each oCPU_CE, and at 1→0 the block SHALL go to HALT.
REQ-025 In STEP, a RUN press SHALL go to HALT and clear oSTEPS_LEFT.
REQ-026 In any state, synchronized iBreak=1 SHALL go to BREAK and clear oSTEPS_LEFT; break has priority over a simultaneous key press or step completion.
REQ-027 BREAK SHALL stay while iBreak=1; once iBreak=0, a RUN press goes to RUN and a STEP press goes to STEP as in HALT.
REQ-028 Simultaneous RUN and STEP presses SHALL be resolved with RUN taking priority.
REQ-029 oSTEPS_LEFT SHALL be 0 in every state other than STEP.

Reset
REQ-030 iRST_n=0 SHALL immediately force oCPU_CLK=0, oCPU_CE=0, oSTATE=HALT, oFAST=0, and oSTEPS_LEFT=0, and SHALL clear all counters, synchronizers (to released-key level 1, break 0) and debounced levels (1).
REQ-031 Reset mid-operation SHALL abort any run or step with no further oCPU_CE; after release the block waits in HALT for a key.

Verification (DEBOUNCE_CYCLES=4, SLOW_SHIFT=2)
REQ-032 Scenario: reset, fast, iFDIV=3, RUN press → oSTATE=01; oCPU_CLK period 6 cycles; oCPU_CE every 6 cycles; first CE 3 cycles after entry.
REQ-033 Scenario: HALT, iSTEP_N=5, iFDIV=1, fast, STEP press → exactly 5 oCPU_CE pulses, oSTEPS_LEFT 5→0, oSTATE=00, oCPU_CLK=0.
REQ-034 Scenario: RUN with iBreak pulsed high for 3 cycles while oCPU_CLK=1 → oSTATE=11; oCPU_CLK falls at the next tick then stays 0; no further CE; RUN press after release → 01.
REQ-035 Scenario: key glitch low for 3 cycles → no state change; low for 6 cycles → exactly one press.
REQ-036 Scenario: slow mode, iFDIV=2 → D=8, oCPU_CLK period 16; iFDIV=0 in fast mode → D=1, period 2.
REQ-037 Scenario: iRST_n low mid-STEP with oSTEPS_LEFT=3 → outputs at reset values asynchronously; no CE after release.
